// File: rtl/cache_flush_sweep_engine_pkg.sv
// Shared types, mode encodings, system defaults and slot-address helper
// for the cache flush/sweep engine.
package PKG_CACHE;

  localparam int SYSTEM_CACHE_FLUSH_ADDR_W          = 64;
  localparam int SYSTEM_CACHE_FLUSH_NUM_WAYS        = 4;
  localparam int SYSTEM_CACHE_FLUSH_NUM_SETS        = 64;
  localparam int SYSTEM_CACHE_FLUSH_LINE_BYTES      = 64;
  localparam int SYSTEM_CACHE_FLUSH_MAX_OUTSTANDING = 8;

  localparam logic CACHE_FLUSH_SET_MAJOR = 1'b0;
  localparam logic CACHE_FLUSH_WAY_MAJOR = 1'b1;

  typedef enum logic [4:0] {
    RESET = 5'b00001,
    IDLE  = 5'b00010,
    ISSUE = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } cache_flush_sweep_state;

  // base + set*LINE_BYTES + way*WAY_STRIDE, shifts only, wraps at 64 bits.
  function automatic logic [63:0] cache_flush_slot_addr(
    input logic [63:0]  base,
    input logic [31:0]  set_idx,
    input logic [31:0]  way_idx,
    input int unsigned  line_log2,
    input int unsigned  way_log2
  );
    return base + (64'(set_idx) << line_log2) + (64'(way_idx) << way_log2);
  endfunction

endpackage

// File: rtl/cache_flush_sweep_engine_if.sv
// Request/ack channel between the sweep engine (master) and the cache port (slave).
interface cache_flush_sweep_engine_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid_out;
  logic              req_ready_in;
  logic [ADDR_W-1:0] req_addr_out;
  logic              resp_ack_in;

  modport master (
    output req_valid_out,
    output req_addr_out,
    input  req_ready_in,
    input  resp_ack_in
  );

  modport slave (
    input  req_valid_out,
    input  req_addr_out,
    output req_ready_in,
    output resp_ack_in
  );
endinterface

// File: rtl/cache_flush_sweep_engine_credit.sv
// Saturating up/down count of requests in flight; full reflects the count
// after this cycle's handshake and ack have been applied.
module cache_flush_credit_counter #(
  parameter int MAX_COUNT = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             inc,
  input  logic                             dec,
  output logic [$clog2(MAX_COUNT+1)-1:0]   count_nxt,
  output logic                             full
);
  localparam int CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count_q;
  logic          inc_ok;
  logic          dec_ok;

  // An ack with nothing in flight refers to no request and is dropped.
  assign inc_ok = inc && (count_q != CW'(MAX_COUNT));
  assign dec_ok = dec && (count_q != '0);

  always_comb begin
    count_nxt = count_q;
    case ({inc_ok, dec_ok})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  assign full = (count_nxt == CW'(MAX_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_nxt;
  end
endmodule

// File: rtl/cache_flush_sweep_engine.sv
// Walks every (set, way) slot and issues one conflicting line read per slot,
// under a credit limit, with abort and drain of outstanding reads.
module cache_flush_sweep_engine
  import PKG_CACHE::*;
#(
  parameter int ADDR_W          = SYSTEM_CACHE_FLUSH_ADDR_W,
  parameter int NUM_WAYS        = SYSTEM_CACHE_FLUSH_NUM_WAYS,
  parameter int NUM_SETS        = SYSTEM_CACHE_FLUSH_NUM_SETS,
  parameter int LINE_BYTES      = SYSTEM_CACHE_FLUSH_LINE_BYTES,
  parameter int MAX_OUTSTANDING = SYSTEM_CACHE_FLUSH_MAX_OUTSTANDING
) (
  input  logic                                      ap_clk,
  input  logic                                      ap_rst_n,
  input  logic                                      start_in,
  input  logic [ADDR_W-1:0]                         base_addr_in,
  input  logic                                      mode_in,
  input  logic                                      abort_in,
  cache_flush_sweep_engine_if.master                req_bus,
  output logic                                      busy_out,
  output logic                                      done_out,
  output logic                                      aborted_out,
  output logic [$clog2(NUM_SETS*NUM_WAYS+1)-1:0]    issued_count_out
);
  localparam int          TOTAL    = NUM_SETS * NUM_WAYS;
  localparam int          CNT_W    = $clog2(TOTAL + 1);
  localparam int          OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LINE_LOG = $clog2(LINE_BYTES);
  localparam int unsigned SET_LOG  = $clog2(NUM_SETS);
  localparam int unsigned WAY_LOG  = $clog2(NUM_WAYS);

  cache_flush_sweep_state state_q;
  logic [ADDR_W-1:0]      base_q;
  logic                   mode_q;
  logic [CNT_W-1:0]       issued_q;
  logic [CNT_W-1:0]       issued_nxt;
  logic                   req_valid_q;
  logic [ADDR_W-1:0]      req_addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   hs;
  logic                   credit_full;
  logic [OUT_W-1:0]       outstanding_nxt;

  // Slot index -> (set, way): the inner index is the low bits of the slot.
  function automatic logic [ADDR_W-1:0] slot_addr(
    input logic [ADDR_W-1:0] base,
    input logic              mode,
    input logic [31:0]       idx
  );
    logic [31:0] s;
    logic [31:0] w;
    if (mode == CACHE_FLUSH_WAY_MAJOR) begin
      s = idx & 32'(NUM_SETS - 1);
      w = idx >> SET_LOG;
    end else begin
      w = idx & 32'(NUM_WAYS - 1);
      s = idx >> WAY_LOG;
    end
    return ADDR_W'(cache_flush_slot_addr(64'(base), s, w, LINE_LOG, LINE_LOG + SET_LOG));
  endfunction

  assign hs         = req_valid_q & req_bus.req_ready_in;
  assign issued_nxt = issued_q + CNT_W'(hs);

  cache_flush_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_credit (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .inc       (hs),
    .dec       (req_bus.resp_ack_in),
    .count_nxt (outstanding_nxt),
    .full      (credit_full)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      mode_q      <= CACHE_FLUSH_SET_MAJOR;
      issued_q    <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q     <= ISSUE;
            base_q      <= base_addr_in;
            mode_q      <= mode_in;
            issued_q    <= '0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
            req_addr_q  <= slot_addr(base_addr_in, mode_in, 32'd0);
          end
        end
        ISSUE: begin
          issued_q <= issued_nxt;
          // Abort wins over a final-slot handshake; that handshake still counts.
          if (abort_in || (hs && (issued_nxt == CNT_W'(TOTAL)))) begin
            state_q     <= DRAIN;
            req_valid_q <= 1'b0;
            aborted_q   <= abort_in;
          end else begin
            req_valid_q <= !credit_full;
            if (hs) req_addr_q <= slot_addr(base_q, mode_q, 32'(issued_nxt));
          end
        end
        DRAIN: begin
          if (outstanding_nxt == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_bus.req_valid_out = req_valid_q;
  assign req_bus.req_addr_out  = req_addr_q;
  assign busy_out              = busy_q;
  assign done_out              = done_q;
  assign aborted_out           = aborted_q;
  assign issued_count_out      = issued_q;
endmodule

// File: doc/cache_flush_sweep_engine.md
# cache_flush_sweep_engine

Parametrised cache flush/sweep address generator for the GLay cache subsystem. On a start pulse it walks every (set, way) slot of a set-associative cache, NUM_SETS × NUM_WAYS requests in total, and issues one line-aligned read request per slot. Each request address is chosen to conflict into the target set, so the sweep evicts (and writes back) every resident line. Compared with the previous linear flush counter, the geometry is fully configurable: it adds way-stride addressing, two walk orders, a credit limit on outstanding requests, and abort.

## Interface
Parameters:
- ADDR_W, 64: request address width.
- NUM_WAYS, 4: cache associativity; must be a power of 2, ≥1.
- NUM_SETS, 64: sets per way; must be a power of 2, ≥1.
- LINE_BYTES, 64: line size in bytes; must be a power of 2.
- MAX_OUTSTANDING, 8: maximum requests in flight (issued but not yet acknowledged); must be ≥1.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- start_in  in  1  one-cycle start pulse; ignored unless the state is IDLE.
- base_addr_in  in  ADDR_W  sweep base address; sampled on an accepted start.
- mode_in  in  1  walk order: 0 = SET_MAJOR, 1 = WAY_MAJOR; sampled on an accepted start.
- abort_in  in  1  stop issuing new requests, then drain.
- req_valid_out  out  1  request valid.
- req_ready_in  in  1  downstream ready.
- req_addr_out  out  ADDR_W  line-aligned request address.
- resp_ack_in  in  1  one completion per asserted cycle.
- busy_out  out  1  high in ISSUE or DRAIN.
- done_out  out  1  one-cycle completion pulse.
- aborted_out  out  1  set on done when the sweep was aborted; held until the next start.
- issued_count_out  out  $clog2(NUM_SETS*NUM_WAYS+1)  requests issued so far.

## Operation
- Constants: WAY_STRIDE = NUM_SETS*LINE_BYTES; TOTAL = NUM_SETS*NUM_WAYS.
- Address for slot (set s, way w) = base + s*LINE_BYTES + w*WAY_STRIDE. Computed with shifts only, truncated modulo 2^ADDR_W (wrap permitted).
- SET_MAJOR: w is the inner index, s the outer. WAY_MAJOR: s is the inner index, w the outer.
- FSM:
  - IDLE → ISSUE on start_in.
  - ISSUE → DRAIN when the last slot is handshaken, or on abort_in.
  - DRAIN → DONE when outstanding == 0.
  - DONE → IDLE after one cycle, with done_out high in that cycle.
- Credit counter `outstanding`:
  - +1 on each request handshake (req_valid_out & req_ready_in).
  - −1 on each resp_ack_in.
  - Both in the same cycle: net 0.
  - req_valid_out is asserted only while outstanding < MAX_OUTSTANDING.
  - An ack arriving while outstanding == 0 is ignored and does not underflow the counter.
- Abort:
  - In ISSUE, abort takes precedence over a simultaneous handshake of the final slot. That handshake still counts, and aborted_out is set.
  - In DRAIN, DONE or IDLE, abort is ignored.
- start_in while busy is ignored; the sweep in progress is not disturbed.

## Timing
- Reset values: req_valid_out=0, req_addr_out=0, busy_out=0, done_out=0, aborted_out=0, issued_count_out=0, outstanding=0, state IDLE.
- All outputs are registered.
- The first req_valid_out appears in the cycle after start is accepted.
- Once req_valid_out is asserted, req_valid_out and req_addr_out hold stable until the handshake (AXI-style).
- After a handshake, the next address is presented in the following cycle: one request per cycle at full throughput with unlimited credit.
- The minimum sweep with immediate acks and req_ready_in tied high is TOTAL + 3 cycles from start to done.
- Reset asserted mid-sweep: everything returns to reset values immediately. No done_out pulse is produced, and any in-flight acks arriving after reset are ignored.

## Structure
- Package PKG_CACHE holds:
  - typedef enum `cache_flush_sweep_state` with one-hot encoding: RESET, IDLE, ISSUE, DRAIN, DONE.
  - mode constants CACHE_FLUSH_SET_MAJOR=0 and CACHE_FLUSH_WAY_MAJOR=1.
  - a function computing the slot address from (base, s, w).
- SYSTEM_CACHE_* flush constants feed the parameter defaults at instantiation.
- One sub-module is natural: `cache_flush_credit_counter`, the saturating up/down outstanding counter with a `full` flag.

## Test plan
All scenarios use NUM_WAYS=4, NUM_SETS=8, LINE_BYTES=64, so WAY_STRIDE=0x200 and TOTAL=32.
- SET_MAJOR, base=0x1000, ready high, immediate ack → addresses 0x1000, 0x1200, 0x1400, 0x1600, 0x1040, …, the last being 0x17C0; 32 requests, done at cycle 35, aborted_out=0.
- WAY_MAJOR, base=0x1000 → addresses 0x1000, 0x1040, …, 0x11C0, 0x1200, …, the last being 0x17C0; issued_count_out=32 at done.
- MAX_OUTSTANDING=2, acks withheld → exactly 2 handshakes, then req_valid_out low; one ack → exactly one further request.
- req_ready_in toggled randomly → req_addr_out is stable while valid and not ready; no address skipped or duplicated.
- abort_in after 5 handshakes, with 3 acks outstanding → no new requests; done_out pulses one cycle after the 3rd ack; aborted_out=1; issued_count_out=5.
- base=0xFFFF_FFFF_FFFF_FF00 → addresses wrap modulo 2^64; ap_rst_n pulled low mid-sweep → all outputs reset, no done_out pulse.
